pulse_stretcher: RTL

Converts single-cycle strobes (the output of the edge-to-pulse stage) back into visible, fixed-length levels. Each accepted pulse produces one high window of HIGH_CYCLES clocks followed by a mandatory low gap of GAP_CYCLES clocks. Pulses that arrive while a window or gap is in progress are queued in a saturating counter and replayed in order. Used to drive LEDs and status lines and to hand multi-cycle strobes to slower consumers in the multiplier demo path.

---
 rtl/pulse_stretcher.sv | 111 +++++++++++
 1 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle strobes into fixed-length high windows
// separated by a mandatory low gap, replaying queued strobes in order.
module pulse_stretcher #(
   parameter int HIGH_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int MAX_PENDING = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           pulse_in,
   output logic                           level_out,
   output logic                           busy,
   output logic [$clog2(MAX_PENDING+1)-1:0] pending,
   output logic                           overflow
);

   localparam int MAXC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int PW   = $clog2(MAX_PENDING+1);

   localparam logic [CW-1:0] HLOAD = CW'(HIGH_CYCLES-1);
   localparam logic [CW-1:0] GLOAD = CW'(GAP_CYCLES-1);
   localparam logic [PW-1:0] PMAX  = PW'(MAX_PENDING);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [PW-1:0]  pend_q, pend_d;
   logic           ovf_q, ovf_d;
   logic           last_gap;

   assign last_gap  = (state_q == GAP) && (cnt_q == '0);
   assign level_out = (state_q == HIGH);
   assign busy      = (state_q != IDLE);
   assign pending   = pend_q;
   assign overflow  = ovf_q;

   // state, window counter, queue depth and drop flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   // next-state, counter reload and pending-queue bookkeeping
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      ovf_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (pulse_in) begin
               state_d = HIGH;
               cnt_d   = HLOAD;
            end
         end
         HIGH: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = GAP;
               cnt_d   = GLOAD;
            end
         end
         GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if ((pend_q != '0) || pulse_in) begin
               state_d = HIGH;
               cnt_d   = HLOAD;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // On the last gap cycle a new pulse either is served directly or
      // takes the slot of the replayed one, so the depth never changes.
      if (state_q != IDLE) begin
         if (pulse_in && !last_gap) begin
            if (pend_q < PMAX) begin
               pend_d = pend_q + 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
         end else if (last_gap && !pulse_in && (pend_q != '0)) begin
            pend_d = pend_q - 1'b1;
         end
      end
   end

endmodule
